// File: rtl/glitc_intercom_pkg.sv
// Shared state type, lane patterns and lane geometry for the GLITC intercom transmit framer.
// Defining GLITC_INTERCOM_PARITY_EN adds one uninverted even-parity lane above the data lanes.
package glitc_intercom_pkg;

    localparam int LANE_BITS = 4;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_TRAIN = 2'd1,
        ST_SYNC  = 2'd2,
        ST_DATA  = 2'd3
    } state_e;

    localparam logic [LANE_BITS-1:0] NIB_IDLE  = 4'b1111;
    localparam logic [LANE_BITS-1:0] NIB_TRAIN = 4'b1010;
    localparam logic [LANE_BITS-1:0] NIB_SYNC  = 4'b1100;

`ifdef GLITC_INTERCOM_PARITY_EN
    localparam int PARITY_LANES = 1;
`else
    localparam int PARITY_LANES = 0;
`endif

endpackage

// File: rtl/glitc_intercom_tx_fifo.sv
// Payload FIFO for the intercom framer: synchronous, first-word-fall-through, with a
// flush that empties it in one edge. Occupancy carries one extra bit to tell full from empty.
module glitc_intercom_tx_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push_s, do_pop_s;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == FULL_CNT);
    assign rdata_o   = mem_q[rd_ptr_q];
    assign do_push_s = push_i & ~full_o;
    assign do_pop_s  = pop_i & ~empty_o;

    // Pointer and occupancy next-state; flush overrides any push or pop in the same cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk_i) begin
        if (do_push_s && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/glitc_intercom_tx_framer.sv
// GLITC intercom transmit framer: builds the OSERDES parallel word from IDLE/TRAIN/SYNC patterns
// and FIFO payload, with periodic SYNC slots. GLITC_INTERCOM_PARITY_EN adds a parity lane.
module glitc_intercom_tx_framer
    import glitc_intercom_pkg::*;
#(
    parameter int                NLANES      = 5,
    parameter int                FIFO_DEPTH  = 4,
    parameter int                SYNC_PERIOD = 64,
    parameter logic [NLANES-1:0] INVERT_MASK = {NLANES{1'b0}}
) (
    input  logic                                         sysclk_i,
    input  logic                                         rst_n_i,
    input  logic                                         en_i,
    input  logic                                         train_i,
    input  logic [NLANES*LANE_BITS-1:0]                  payload_i,
    input  logic                                         valid_i,
    output logic                                         ready_o,
    output logic [(NLANES+PARITY_LANES)*LANE_BITS-1:0]   oq_data_o,
    output logic                                         oce_o,
    output logic                                         frame_o,
    output logic                                         underrun_o
);

    localparam int DW = NLANES * LANE_BITS;
    localparam int OW = (NLANES + PARITY_LANES) * LANE_BITS;
    localparam int CW = $clog2(SYNC_PERIOD);

    localparam logic [CW-1:0] SLOT_LAST  = CW'(SYNC_PERIOD - 1);
    localparam logic [CW-1:0] SLOT_ONE   = CW'(1);
    localparam logic [DW-1:0] IDLE_WORD  = {NLANES{NIB_IDLE}};
    localparam logic [DW-1:0] TRAIN_WORD = {NLANES{NIB_TRAIN}};
    localparam logic [DW-1:0] SYNC_WORD  = {NLANES{NIB_SYNC}};

    function automatic logic [DW-1:0] expand_mask(input logic [NLANES-1:0] m);
        logic [DW-1:0] bits;
        bits = '0;
        for (int i = 0; i < NLANES; i++) begin
            bits[i*LANE_BITS +: LANE_BITS] = {LANE_BITS{m[i]}};
        end
        return bits;
    endfunction

    localparam logic [DW-1:0] INV_BITS = expand_mask(INVERT_MASK);

`ifdef GLITC_INTERCOM_PARITY_EN
    localparam logic [OW-1:0] RST_WORD = {NIB_IDLE, IDLE_WORD ^ INV_BITS};

    function automatic logic [LANE_BITS-1:0] lane_parity(input logic [DW-1:0] w);
        logic [LANE_BITS-1:0] p;
        p = 4'h0;
        for (int i = 0; i < NLANES; i++) begin
            p = p ^ w[i*LANE_BITS +: LANE_BITS];
        end
        return p;
    endfunction
`else
    localparam logic [OW-1:0] RST_WORD = IDLE_WORD ^ INV_BITS;
`endif

    state_e          state_q, state_d;
    logic [CW-1:0]   slot_q, slot_d;
    logic [OW-1:0]   oq_q;
    logic            oce_q, frame_q, underrun_q, run_q;

    logic [DW-1:0]   word_s;
    logic [OW-1:0]   out_s;
    logic            pop_s, frame_s, underrun_s;
    logic            push_s, flush_s;
    logic [DW-1:0]   fifo_rdata_s;
    logic            fifo_empty_s, fifo_full_s;

    assign ready_o    = run_q & ~fifo_full_s;
    assign push_s     = valid_i & ready_o;
    assign flush_s    = ~en_i;
    assign oq_data_o  = oq_q;
    assign oce_o      = oce_q;
    assign frame_o    = frame_q;
    assign underrun_o = underrun_q;

    glitc_intercom_tx_fifo #(
        .WIDTH (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (sysclk_i),
        .rst_n_i (rst_n_i),
        .flush_i (flush_s),
        .push_i  (push_s),
        .wdata_i (payload_i),
        .pop_i   (pop_s),
        .rdata_o (fifo_rdata_s),
        .empty_o (fifo_empty_s),
        .full_o  (fifo_full_s)
    );

    // Link state, slot counter and pre-inversion lane word for the current cycle.
    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        word_s     = IDLE_WORD;
        pop_s      = 1'b0;
        frame_s    = 1'b0;
        underrun_s = 1'b0;
        if (!en_i) begin
            state_d = ST_OFF;
            slot_d  = '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    if (train_i) begin
                        state_d = ST_TRAIN;
                    end else begin
                        state_d = ST_SYNC;
                    end
                end
                ST_TRAIN: begin
                    word_s = TRAIN_WORD;
                    if (train_i) begin
                        state_d = ST_TRAIN;
                    end else begin
                        state_d = ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    word_s  = SYNC_WORD;
                    frame_s = 1'b1;
                    slot_d  = '0;
                    state_d = ST_DATA;
                end
                ST_DATA: begin
                    // The last slot of each period is reserved for SYNC and never pops.
                    if (slot_q == SLOT_LAST) begin
                        slot_d  = '0;
                        word_s  = SYNC_WORD;
                        frame_s = 1'b1;
                    end else begin
                        slot_d = slot_q + SLOT_ONE;
                        if (fifo_empty_s) begin
                            underrun_s = 1'b1;
                        end else begin
                            pop_s  = 1'b1;
                            word_s = fifo_rdata_s;
                        end
                    end
                    if (train_i) begin
                        state_d = ST_TRAIN;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    slot_d  = '0;
                end
            endcase
        end
    end

`ifdef GLITC_INTERCOM_PARITY_EN
    logic                 in_data_s;
    logic [LANE_BITS-1:0] par_lane_s;

    assign in_data_s = en_i & (state_q == ST_DATA);

    // Parity lane: even parity of the un-inverted data lanes in DATA, the state pattern elsewhere.
    always_comb begin
        if (in_data_s) begin
            par_lane_s = lane_parity(word_s);
        end else begin
            par_lane_s = word_s[LANE_BITS-1:0];
        end
    end

    assign out_s = {par_lane_s, word_s ^ INV_BITS};
`else
    assign out_s = word_s ^ INV_BITS;
`endif

    // State, slot counter and registered output stage.
    always_ff @(posedge sysclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_OFF;
            slot_q     <= '0;
            oq_q       <= RST_WORD;
            oce_q      <= 1'b0;
            frame_q    <= 1'b0;
            underrun_q <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            oq_q       <= out_s;
            oce_q      <= en_i;
            frame_q    <= frame_s;
            underrun_q <= underrun_s;
            run_q      <= 1'b1;
        end
    end

endmodule

// File: tb/tb_glitc_intercom_tx_framer.sv
// Randomised self-checking bench for glitc_intercom_tx_framer against a queue-based link model.
module tb_glitc_intercom_tx_framer;
    import glitc_intercom_pkg::*;

    localparam int NL  = 5;
    localparam int DEP = 4;
    localparam int SP  = 8;
    localparam logic [NL-1:0] MASK = 5'b00010;
    localparam int DW  = NL * 4;
    localparam int OW  = (NL + PARITY_LANES) * 4;

    localparam int M_OFF   = 0;
    localparam int M_TRAIN = 1;
    localparam int M_SYNC  = 2;
    localparam int M_DATA  = 3;

    logic          clk = 1'b0;
    logic          rst_n_i, en_i, train_i, valid_i;
    logic [DW-1:0] payload_i;
    logic          ready_o, oce_o, frame_o, underrun_o;
    logic [OW-1:0] oq_data_o;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] m_q[$];
    int            m_phase;
    int            m_since;
    bit            m_run;
    logic [OW-1:0] e_oq;
    bit            e_oce, e_frame, e_und;

    always #5 clk = ~clk;

    glitc_intercom_tx_framer #(
        .NLANES      (NL),
        .FIFO_DEPTH  (DEP),
        .SYNC_PERIOD (SP),
        .INVERT_MASK (MASK)
    ) dut (
        .sysclk_i   (clk),
        .rst_n_i    (rst_n_i),
        .en_i       (en_i),
        .train_i    (train_i),
        .payload_i  (payload_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .oq_data_o  (oq_data_o),
        .oce_o      (oce_o),
        .frame_o    (frame_o),
        .underrun_o (underrun_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rep(input logic [3:0] nib);
        logic [DW-1:0] w;
        for (int i = 0; i < NL; i++) w[i*4 +: 4] = nib;
        return w;
    endfunction

    function automatic logic [OW-1:0] frame_word(input logic [DW-1:0] lanes, input bit in_data);
        logic [OW-1:0] w;
        logic [3:0]    par;
        w   = '0;
        par = 4'h0;
        for (int i = 0; i < NL; i++) begin
            par = par ^ lanes[i*4 +: 4];
            w[i*4 +: 4] = MASK[i] ? ~lanes[i*4 +: 4] : lanes[i*4 +: 4];
        end
        if (PARITY_LANES != 0) w[OW-1 -: 4] = in_data ? par : lanes[3:0];
        return w;
    endfunction

    function automatic bit exp_ready();
        return m_run && (m_q.size() < DEP);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_phase = M_OFF;
        m_since = 0;
        m_run   = 1'b0;
        e_oq    = frame_word(rep(4'hF), 1'b0);
        e_oce   = 1'b0;
        e_frame = 1'b0;
        e_und   = 1'b0;
    endtask

    // One rising edge of the link as seen from outside, using the inputs held over the cycle.
    task automatic model_step();
        bit            push_ok;
        bit            in_data;
        logic [DW-1:0] lanes;
        push_ok = valid_i && exp_ready();
        m_run   = 1'b1;
        e_oce   = en_i;
        e_frame = 1'b0;
        e_und   = 1'b0;
        in_data = 1'b0;
        lanes   = rep(4'hF);
        if (!en_i) begin
            m_q.delete();
            m_phase = M_OFF;
        end else begin
            if (m_phase == M_OFF) begin
                m_phase = train_i ? M_TRAIN : M_SYNC;
            end else if (m_phase == M_TRAIN) begin
                lanes   = rep(4'hA);
                m_phase = train_i ? M_TRAIN : M_SYNC;
            end else if (m_phase == M_SYNC) begin
                lanes   = rep(4'hC);
                e_frame = 1'b1;
                m_since = 0;
                m_phase = M_DATA;
            end else begin
                in_data = 1'b1;
                m_since++;
                if (m_since == SP) begin
                    m_since = 0;
                    lanes   = rep(4'hC);
                    e_frame = 1'b1;
                end else if (m_q.size() > 0) begin
                    lanes = m_q.pop_front();
                end else begin
                    e_und = 1'b1;
                end
                if (train_i) m_phase = M_TRAIN;
            end
            if (push_ok) m_q.push_back(payload_i);
        end
        e_oq = frame_word(lanes, in_data);
    endtask

    task automatic check_outputs();
        check("oq_data", 64'(oq_data_o), 64'(e_oq));
        check("oce", 64'(oce_o), 64'(e_oce));
        check("frame", 64'(frame_o), 64'(e_frame));
        check("underrun", 64'(underrun_o), 64'(e_und));
    endtask

    // Called at a falling edge: drive, check ready, take one rising edge, check outputs.
    task automatic cyc(input bit en, input bit tr, input bit val, input logic [DW-1:0] pl);
        en_i      = en;
        train_i   = tr;
        valid_i   = val;
        payload_i = pl;
        #1;
        check("ready", 64'(ready_o), 64'(exp_ready()));
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic mid_reset();
        en_i    = 1'b1;
        train_i = 1'b0;
        valid_i = 1'b1;
        payload_i = DW'($urandom());
        @(posedge clk);
        model_step();
        #2;
        rst_n_i = 1'b0;
        model_reset();
        #1;
        check_outputs();
        check("ready_in_reset", 64'(ready_o), 64'(1'b0));
        @(negedge clk);
        rst_n_i = 1'b1;
    endtask

    initial begin
        logic [DW-1:0] next_pl;
        rst_n_i   = 1'b0;
        en_i      = 1'b0;
        train_i   = 1'b0;
        valid_i   = 1'b0;
        payload_i = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_lanes", 64'(oq_data_o[DW-1:0]), 64'(20'hFFF0F));
        check_outputs();
        check("reset_ready", 64'(ready_o), 64'(1'b0));
        rst_n_i = 1'b1;

        // Training, then release into SYNC and DATA.
        cyc(1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, '0);
        cyc(1'b1, 1'b0, 1'b0, '0);
        cyc(1'b1, 1'b0, 1'b0, '0);

        // Continuous counting payload; the FIFO fills because SYNC slots do not pop.
        next_pl = 20'h00001;
        for (int i = 0; i < 48; i++) begin
            bit acc;
            acc = exp_ready();
            cyc(1'b1, 1'b0, 1'b1, next_pl);
            if (acc) next_pl = next_pl + 20'h00001;
        end

        // Drain and starve.
        for (int i = 0; i < 14; i++) cyc(1'b1, 1'b0, 1'b0, '0);
        cyc(1'b1, 1'b0, 1'b1, 20'h12345);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, '0);

        // Park in TRAIN with 3 words, drop the link, re-enable.
        cyc(1'b1, 1'b1, 1'b0, '0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b1, DW'($urandom()));
        cyc(1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, 1'b0, '0);

        // Randomised traffic with an asynchronous reset in the middle.
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) mid_reset();
            cyc(($urandom_range(0, 99) < 96),
                ($urandom_range(0, 99) < 4),
                ($urandom_range(0, 99) < 65),
                DW'($urandom()));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/glitc_intercom_tx_framer.md
GLITC_INTERCOM_TX_FRAMER -- requirements
Module: glitc_intercom_tx_framer

Interface
REQ-001 Parameter NLANES, default 5: number of data lanes, 1..16.
REQ-002 Parameter FIFO_DEPTH, default 4: payload FIFO entries, power of two, 2..32.
REQ-003 Parameter SYNC_PERIOD, default 64: DATA-state cycles per sync slot, 4..1024.
REQ-004 Parameter INVERT_MASK, default 0: NLANES-bit mask; bit i set inverts lane i.
REQ-005 Port sysclk_i, input, 1 bit: the only clock; all logic on its rising edge.
REQ-006 Port rst_n_i, input, 1 bit: asynchronous active-low reset.
REQ-007 Port en_i, input, 1 bit: link enable.
REQ-008 Port train_i, input, 1 bit: request the training pattern.
REQ-009 Port payload_i, input, NLANES*4 bits: one word per beat; lane i occupies [4i+:4].
REQ-010 Port valid_i, input, 1 bit: payload_i valid.
REQ-011 Port ready_o, output, 1 bit: FIFO not full.
REQ-012 Port oq_data_o, output, LW*4 bits: registered OSERDES parallel word; bit 4i+3 is serialised first. LW = NLANES, or NLANES+1 per REQ-027.
REQ-013 Port oce_o, output, 1 bit: OSERDES clock enable, en_i delayed by one register.
REQ-014 Port frame_o, output, 1 bit: high in the same cycle that oq_data_o carries SYNC.
REQ-015 Port underrun_o, output, 1 bit: one-cycle pulse for a DATA slot sent with an empty FIFO.

Function
REQ-016 Per-lane nibble patterns: IDLE 4'b1111, TRAIN 4'b1010, SYNC 4'b1100, applied identically to all lanes.
REQ-017 States: OFF, TRAIN, SYNC, DATA.
- OFF: output IDLE.
- From OFF: en_i&train_i -> TRAIN; en_i&!train_i -> SYNC.
REQ-018 TRAIN: outputs TRAIN; !train_i -> SYNC.
REQ-019 SYNC: lasts exactly one cycle, outputs SYNC, asserts frame_o, clears the slot counter, then -> DATA.
REQ-020 DATA slot handling:
- Each cycle increments the slot counter.
- Counter value SYNC_PERIOD-1: emit SYNC with frame_o, no pop, counter wraps to 0.
- Otherwise pop the FIFO head onto oq_data_o.
- Empty FIFO: emit IDLE and pulse underrun_o.
REQ-021 DATA with train_i=1 -> TRAIN at the next edge; the FIFO is retained.
REQ-022 en_i=0 in any state -> OFF at the next edge; the FIFO is flushed in the same cycle; ready_o=1 afterwards.
REQ-023 Push when valid_i&ready_o; ready_o=!full. A simultaneous push and pop is legal at any occupancy, including when 1 entry is present. A word pushed into an empty FIFO on edge k appears on oq_data_o after edge k+1 when slot k+1 is a data slot.
REQ-024 Pointers wrap modulo FIFO_DEPTH; an occupancy counter of width log2(FIFO_DEPTH)+1 distinguishes full from empty.
REQ-025 Lane inversion per INVERT_MASK is applied last, after pattern and parity selection, to every state's output including IDLE.

Reset
REQ-026 While rst_n_i=0:
- state=OFF, FIFO empty, slot counter 0;
- oq_data_o = IDLE per lane, with INVERT_MASK applied;
- oce_o=0, frame_o=0, underrun_o=0, ready_o=0.
After release: ready_o=1 from the first edge; rst_n_i asserted mid-frame aborts immediately, with no partial word.

Configuration
REQ-027 Macro GLITC_INTERCOM_PARITY_EN.
- Defined: one extra lane at index NLANES. In DATA it carries per-bit even parity, bit b = XOR of bit b over all data lanes before inversion. In other states it carries the state pattern. It is never inverted.
- Undefined: LW=NLANES and no parity logic.

Structure
REQ-028 Package glitc_intercom_pkg holds:
- the state enum;
- IDLE/TRAIN/SYNC nibble constants;
- LANE_BITS=4.
REQ-029 FIFO is sub-module glitc_intercom_tx_fifo: synchronous, first-word-fall-through, with flush input.

Verification
REQ-030 Reset, NLANES=5, INVERT_MASK=5'b00010 -> oq_data_o=20'hFFF0F, oce_o=0, ready_o=0.
REQ-031 en_i=1, train_i=1 -> oce_o=1 after one edge; oq_data_o=20'hAAAAA until train_i falls; then one SYNC 20'hCCCCC with frame_o=1.
REQ-032 DATA, SYNC_PERIOD=8, continuous payloads 1,2,3,...:
- outputs in order;
- SYNC every 8th cycle;
- no word lost or duplicated across the sync slot, with ready_o dropping when the FIFO fills.
REQ-033 DATA with an empty FIFO -> 20'hFFFFF and underrun_o pulses each slot; push 20'h12345 -> it appears on the next edge.
REQ-034 FIFO holding 3 words, en_i->0 -> OFF, output IDLE, FIFO empty; re-enable -> SYNC first, with no stale words.
REQ-035 With GLITC_INTERCOM_PARITY_EN, payload 20'h0000F -> parity lane 4'hF and oq_data_o=24'hF0000F.
